fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main decoder. Owns the fetch PC and issues requests to instruction memory. Absorbs memory wait states, decode stalls, execute-stage redirects and flushes. Presents instruction, PC and PC+4 to decode, with op_d (instr_d[6:0]) wired straight to the decoder's Op input.

---
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Handles memory wait
// states, decode stalls (via a one-entry hold buffer), redirects and flushes.
module fetch_stage #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   input  logic            stall_d,
   input  logic            flush_d,
   input  logic            pc_src_e,
   input  logic [XLEN-1:0] pc_target_e,
   output logic [31:0]     instr_d,
   output logic [6:0]      op_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pc_plus4_d,
   output logic            valid_d
);

   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      FETCH = 2'b01,
      HOLD  = 2'b10
   } state_e;

   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] LOW_MASK = ~XLEN'(3);

   state_e          state_q, state_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] pc_f_q, pc_f_d;

   logic [31:0]     ifid_instr_q, ifid_instr_d;
   logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
   logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
   logic            ifid_vld_q, ifid_vld_d;

   logic [31:0]     hold_instr_q, hold_instr_d;
   logic [XLEN-1:0] hold_pc_q, hold_pc_d;
   logic [XLEN-1:0] hold_pc4_q, hold_pc4_d;
   logic            hold_full_q, hold_full_d;

   logic            complete;
   logic [XLEN-1:0] pc_next;

   // A response arriving alongside a redirect belongs to the wrong path.
   assign complete = req_q & imem_ready & ~pc_src_e;
   assign pc_next  = pc_f_q + PC_STEP;

   always_comb begin
      state_d      = state_q;
      pc_f_d       = pc_f_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_vld_d   = ifid_vld_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      hold_pc4_d   = hold_pc4_q;
      hold_full_d  = hold_full_q;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (complete) begin
               pc_f_d = pc_next;
               // IF/ID cannot take it (stalled or being flushed): park it.
               if (stall_d || flush_d) begin
                  hold_instr_d = imem_rdata;
                  hold_pc_d    = pc_f_q;
                  hold_pc4_d   = pc_next;
                  hold_full_d  = 1'b1;
                  state_d      = HOLD;
               end else begin
                  ifid_instr_d = imem_rdata;
                  ifid_pc_d    = pc_f_q;
                  ifid_pc4_d   = pc_next;
                  ifid_vld_d   = 1'b1;
               end
            end else if (!stall_d) begin
               ifid_instr_d = NOP_INSTR;
               ifid_vld_d   = 1'b0;
            end
         end
         HOLD: begin
            if (!stall_d && !flush_d) begin
               ifid_instr_d = hold_instr_q;
               ifid_pc_d    = hold_pc_q;
               ifid_pc4_d   = hold_pc4_q;
               ifid_vld_d   = hold_full_q;
               hold_full_d  = 1'b0;
               state_d      = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      if (flush_d) begin
         ifid_instr_d = NOP_INSTR;
         ifid_vld_d   = 1'b0;
      end

      if (pc_src_e) begin
         pc_f_d      = pc_target_e & LOW_MASK;
         hold_full_d = 1'b0;
         state_d     = (state_q == BOOT) ? BOOT : FETCH;
      end

      req_d = (state_d == FETCH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         req_q        <= 1'b0;
         pc_f_q       <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_vld_q   <= 1'b0;
         hold_instr_q <= NOP_INSTR;
         hold_pc_q    <= '0;
         hold_pc4_q   <= '0;
         hold_full_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         pc_f_q       <= pc_f_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_vld_q   <= ifid_vld_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         hold_pc4_q   <= hold_pc4_d;
         hold_full_q  <= hold_full_d;
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = pc_f_q;
   assign instr_d    = ifid_instr_q;
   assign op_d       = ifid_instr_q[6:0];
   assign pc_d       = ifid_pc_q;
   assign pc_plus4_d = ifid_pc4_q;
   assign valid_d    = ifid_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the main sequence and a
// second instance with RESET_PC near the top of the address space.
module tb_fetch_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: RESET_PC = 0
   logic        rst_n, ready, stall, flush, src;
   logic [31:0] tgt;
   logic        req;
   logic [31:0] addr, rdata, instr, pcd, pc4;
   logic [6:0]  op;
   logic        vld;

   // Instance B: RESET_PC = FFFF_FFFC
   logic        rst_n2, ready2;
   logic        zero_b = 1'b0;
   logic [31:0] zero_w = 32'h0;
   logic        req2;
   logic [31:0] addr2, rdata2, instr2, pcd2, pc42;
   logic [6:0]  op2;
   logic        vld2;

   assign rdata  = addr  ^ 32'hA5A5_0000;
   assign rdata2 = addr2 ^ 32'hA5A5_0000;

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut_a (
      .clk(clk), .rst_n(rst_n), .imem_req(req), .imem_addr(addr),
      .imem_ready(ready), .imem_rdata(rdata), .stall_d(stall), .flush_d(flush),
      .pc_src_e(src), .pc_target_e(tgt), .instr_d(instr), .op_d(op),
      .pc_d(pcd), .pc_plus4_d(pc4), .valid_d(vld)
   );

   fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_b (
      .clk(clk), .rst_n(rst_n2), .imem_req(req2), .imem_addr(addr2),
      .imem_ready(ready2), .imem_rdata(rdata2), .stall_d(zero_b), .flush_d(zero_b),
      .pc_src_e(zero_b), .pc_target_e(zero_w), .instr_d(instr2), .op_d(op2),
      .pc_d(pcd2), .pc_plus4_d(pc42), .valid_d(vld2)
   );

   typedef struct {
      logic        rdy, stl, fls, src;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr, instr, pcd, pc4;
      logic        vld;
   } vec_t;

   vec_t vecs [20];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_b_reset(input string tag);
      check({tag, " req"},   {31'b0, req2}, 32'h0);
      check({tag, " addr"},  addr2,         32'hFFFF_FFFC);
      check({tag, " instr"}, instr2,        32'h0000_0013);
      check({tag, " pc_d"},  pcd2,          32'h0);
      check({tag, " pc4"},   pc42,          32'h0);
      check({tag, " valid"}, {31'b0, vld2}, 32'h0);
   endtask

   initial begin
      //           rdy   stl   fls   src   tgt            req   addr          instr         pc_d          pc4           vld
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        32'h13,       32'h0,        32'h0,        1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,        32'h13,       32'h0,        32'h0,        1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,        32'hA5A50000, 32'h0,        32'h4,        1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        32'hA5A50004, 32'h4,        32'h8,        1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        32'h13,       32'h4,        32'h8,        1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        32'h13,       32'h4,        32'h8,        1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        32'h13,       32'h4,        32'h8,        1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,        32'hA5A50008, 32'h8,        32'hC,        1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10,       32'hA5A50008, 32'h8,        32'hC,        1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10,       32'hA5A50008, 32'h8,        32'hC,        1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10,       32'hA5A50008, 32'h8,        32'hC,        1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h10,       32'hA5A50008, 32'h8,        32'hC,        1'b1};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10,       32'hA5A5000C, 32'hC,        32'h10,       1'b1};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h103,       1'b1, 32'h14,       32'hA5A50010, 32'h10,       32'h14,       1'b1};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,      32'h13,       32'h10,       32'h14,       1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h104,      32'hA5A50100, 32'h100,      32'h104,      1'b1};
      vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h104,      32'h13,       32'h100,      32'h104,      1'b0};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h108,      32'h13,       32'h100,      32'h104,      1'b0};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h108,      32'hA5A50104, 32'h104,      32'h108,      1'b1};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h10C,      32'hA5A50108, 32'h108,      32'h10C,      1'b1};

      rst_n = 1'b0; rst_n2 = 1'b0;
      ready = 1'b0; stall = 1'b0; flush = 1'b0; src = 1'b0; tgt = 32'h0;
      ready2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("A reset req",   {31'b0, req}, 32'h0);
      check("A reset addr",  addr,         32'h0);
      check("A reset instr", instr,        32'h13);
      check("A reset pc_d",  pcd,          32'h0);
      check("A reset pc4",   pc4,          32'h0);
      check("A reset valid", {31'b0, vld}, 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         ready = vecs[i].rdy; stall = vecs[i].stl; flush = vecs[i].fls;
         src = vecs[i].src;   tgt = vecs[i].tgt;
         check($sformatf("A[%0d] req", i),   {31'b0, req}, {31'b0, vecs[i].req});
         check($sformatf("A[%0d] addr", i),  addr,         vecs[i].addr);
         check($sformatf("A[%0d] instr", i), instr,        vecs[i].instr);
         check($sformatf("A[%0d] op", i),    {25'b0, op},  {25'b0, vecs[i].instr[6:0]});
         check($sformatf("A[%0d] pc_d", i),  pcd,          vecs[i].pcd);
         check($sformatf("A[%0d] pc4", i),   pc4,          vecs[i].pc4);
         check($sformatf("A[%0d] valid", i), {31'b0, vld}, {31'b0, vecs[i].vld});
         @(posedge clk);
         #1;
      end
      ready = 1'b0; stall = 1'b0; flush = 1'b0; src = 1'b0;

      // Instance B: wrap at the top of the address space, then reset mid-wait.
      check_b_reset("B reset");
      rst_n2 = 1'b1;
      ready2 = 1'b1;
      check("B c0 req",  {31'b0, req2}, 32'h0);
      check("B c0 addr", addr2,         32'hFFFF_FFFC);
      @(posedge clk); #1;
      check("B c1 req",  {31'b0, req2}, 32'h1);
      check("B c1 addr", addr2,         32'hFFFF_FFFC);
      @(posedge clk); #1;
      ready2 = 1'b0;
      check("B c2 addr",  addr2,         32'h0);
      check("B c2 instr", instr2,        32'h5A5A_FFFC);
      check("B c2 pc_d",  pcd2,          32'hFFFF_FFFC);
      check("B c2 pc4",   pc42,          32'h0);
      check("B c2 valid", {31'b0, vld2}, 32'h1);
      @(posedge clk); #1;
      check("B c3 req",   {31'b0, req2}, 32'h1);
      check("B c3 addr",  addr2,         32'h0);
      check("B c3 valid", {31'b0, vld2}, 32'h0);
      #2 rst_n2 = 1'b0;
      #1;
      check_b_reset("B async reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
